uart_alu_ctrl: RTL

UART_ALU_CTRL -- requirements
Module: uart_alu_ctrl

---
 rtl/uart_alu_ctrl.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/uart_alu_ctrl.sv
// Frame controller between a UART and a combinational ALU: collects A, B and
// opcode bytes, runs one ALU operation and sends the result byte back.
module uart_alu_ctrl #(
  parameter int NB_DATA        = 8,
  parameter int NB_OP          = 6,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done_tick,
  input  logic               i_tx_done_tick,
  input  logic [NB_DATA-1:0] i_alu_result,
  output logic [NB_DATA-1:0] o_alu_a,
  output logic [NB_DATA-1:0] o_alu_b,
  output logic [NB_OP-1:0]   o_alu_op,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_busy,
  output logic               o_error
);

  localparam int NB_CNT = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_WAIT_A,
    ST_WAIT_B,
    ST_WAIT_OP,
    ST_EXEC,
    ST_SEND,
    ST_WAIT_TX
  } state_t;

  state_t             r_state, w_state_next;
  logic [NB_DATA-1:0] r_alu_a, w_alu_a_next;
  logic [NB_DATA-1:0] r_alu_b, w_alu_b_next;
  logic [NB_OP-1:0]   r_alu_op, w_alu_op_next;
  logic [NB_DATA-1:0] r_tx_data, w_tx_data_next;
  logic [NB_CNT-1:0]  r_cnt, w_cnt_next;
  logic               r_error, w_error_next;
  logic               w_op_valid;
  logic               w_timeout;
  logic [NB_OP-1:0]   w_rx_op;

  assign w_rx_op   = i_rx_data[NB_OP-1:0];
  assign w_timeout = (r_cnt == CNT_LAST);

  always_comb begin
    case (w_rx_op)
      NB_OP'(6'b100000), NB_OP'(6'b100010), NB_OP'(6'b100100),
      NB_OP'(6'b100101), NB_OP'(6'b100110), NB_OP'(6'b000011),
      NB_OP'(6'b000010), NB_OP'(6'b100111): w_op_valid = 1'b1;
      default:                              w_op_valid = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= ST_WAIT_A;
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_op  <= '0;
      r_tx_data <= '0;
      r_cnt     <= '0;
      r_error   <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_alu_a   <= w_alu_a_next;
      r_alu_b   <= w_alu_b_next;
      r_alu_op  <= w_alu_op_next;
      r_tx_data <= w_tx_data_next;
      r_cnt     <= w_cnt_next;
      r_error   <= w_error_next;
    end
  end

  // A byte arriving on the timeout cycle wins over the timeout.
  always_comb begin
    w_state_next   = r_state;
    w_alu_a_next   = r_alu_a;
    w_alu_b_next   = r_alu_b;
    w_alu_op_next  = r_alu_op;
    w_tx_data_next = r_tx_data;
    w_cnt_next     = '0;
    w_error_next   = 1'b0;
    case (r_state)
      ST_WAIT_A: begin
        if (i_rx_done_tick) begin
          w_alu_a_next = i_rx_data;
          w_state_next = ST_WAIT_B;
        end
      end
      ST_WAIT_B: begin
        if (i_rx_done_tick) begin
          w_alu_b_next = i_rx_data;
          w_state_next = ST_WAIT_OP;
        end else if (w_timeout) begin
          w_error_next = 1'b1;
          w_state_next = ST_WAIT_A;
        end else begin
          w_cnt_next = r_cnt + NB_CNT'(1);
        end
      end
      ST_WAIT_OP: begin
        if (i_rx_done_tick) begin
          if (w_op_valid) begin
            w_alu_op_next = w_rx_op;
            w_state_next  = ST_EXEC;
          end else begin
            w_error_next = 1'b1;
            w_state_next = ST_WAIT_A;
          end
        end else if (w_timeout) begin
          w_error_next = 1'b1;
          w_state_next = ST_WAIT_A;
        end else begin
          w_cnt_next = r_cnt + NB_CNT'(1);
        end
      end
      ST_EXEC: begin
        w_tx_data_next = i_alu_result;
        w_state_next   = ST_SEND;
      end
      ST_SEND: begin
        w_state_next = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        if (i_tx_done_tick) w_state_next = ST_WAIT_A;
      end
      default: w_state_next = ST_WAIT_A;
    endcase
  end

  assign o_alu_a    = r_alu_a;
  assign o_alu_b    = r_alu_b;
  assign o_alu_op   = r_alu_op;
  assign o_tx_data  = r_tx_data;
  assign o_error    = r_error;
  assign o_tx_start = (r_state == ST_SEND);
  assign o_busy     = (r_state == ST_EXEC) || (r_state == ST_SEND) ||
                      (r_state == ST_WAIT_TX);

endmodule
